imm_extend_pipe: RTL

//  Parametrised, registered immediate-extension stage for the decode->execute path.

---
 rtl/imm_ext_pkg.sv | 15 +
 rtl/imm_extend_pipe_if.sv | 29 ++
 rtl/imm_ext_core.sv | 36 +++
 rtl/imm_extend_pipe.sv | 86 ++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage.
// Mode encodings and the output-width sanity check used at elaboration.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SEXT     = 2'b00;
    localparam logic [1:0] MODE_ZEXT     = 2'b01;
    localparam logic [1:0] MODE_SEXT_SHL = 2'b10;
    localparam logic [1:0] MODE_UPPER    = 2'b11;

    // The shifted form must fit without losing its sign bit.
    function automatic bit width_ok(int in_w, int out_w, int shift);
        return out_w >= in_w + shift;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode, the extension stage and execute.
// Ports: in_* side (valid/ready/imm/mode/tag), out_* side (valid/ready/data/tag).
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    // Environment view: drives the producer side and the consumer ready.
    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Stage view.
    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate widener: (imm, mode) -> OUT_W result.
// Ports: imm (IN_W), mode (2), result (OUT_W).
import imm_ext_pkg::*;

module imm_ext_core #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;

    if (!width_ok(IN_W, OUT_W, SHIFT)) begin : g_width_err
        $error("imm_ext_core: OUT_W must be >= IN_W+SHIFT");
    end

    assign sext  = OUT_W'($signed(imm));
    assign zext  = OUT_W'(imm);
    assign upper = zext << (OUT_W - IN_W);

    always_comb begin
        result = '0;
        unique case (mode)
            MODE_SEXT:     result = sext;
            MODE_ZEXT:     result = zext;
            MODE_SEXT_SHL: result = sext << SHIFT;
            MODE_UPPER:    result = upper;
            default:       result = '0;
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer.
// Ports: clk, rst_n (async, active-low), flush, bus (slave handshake bundle).
import imm_ext_pkg::*;

module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int TAG_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    imm_extend_pipe_if.slave bus
);
    logic [1:0]       count;
    logic [OUT_W-1:0] head_data;
    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] skid_tag;
    logic [OUT_W-1:0] ext;
    logic             push;
    logic             pop;

    if (!width_ok(IN_W, OUT_W, SHIFT)) begin : g_width_err
        $error("imm_extend_pipe: OUT_W must be >= IN_W+SHIFT");
    end

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_core (
        .imm    (bus.in_imm),
        .mode   (bus.in_mode),
        .result (ext)
    );

    // Ready comes from registered occupancy only, never from out_ready.
    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = head_data;
    assign bus.out_tag   = head_tag;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head_data <= '0;
            head_tag  <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else if (flush) begin
            // Head is left as-is; it is don't-care once invalid.
            count <= 2'd0;
        end else begin
            unique case (1'b1)
                // Only reachable at count=1: replace the head in place.
                push && pop: begin
                    head_data <= ext;
                    head_tag  <= bus.in_tag;
                end
                push && !pop: begin
                    if (count == 2'd0) begin
                        head_data <= ext;
                        head_tag  <= bus.in_tag;
                    end else begin
                        skid_data <= ext;
                        skid_tag  <= bus.in_tag;
                    end
                    count <= count + 2'd1;
                end
                !push && pop: begin
                    if (count == 2'd2) begin
                        head_data <= skid_data;
                        head_tag  <= skid_tag;
                    end
                    count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
